// File: rtl/sudoku_pkg.sv
// Shared button indices and debounce FSM state encoding for the sudoku front end.
package sudoku_pkg;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_START = 4;
  localparam int unsigned BTN_A     = 5;
  localparam int unsigned BTN_B     = 6;
  localparam int unsigned BTN_COUNT = 7;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } debounce_state_t;

endpackage

// File: rtl/button_conditioner_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, registered press pulse and level.
// Optional auto-repeat while held is built only when AUTO_REPEAT_EN is defined.
module button_debounce_ch
  import sudoku_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          REPEAT_ALLOWED  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_accept;
  logic             rpt_fire;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], raw};
  end

  assign sync = sync_q[1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    press_accept = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = HELD;
          press_accept = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

`ifdef AUTO_REPEAT_EN
  if (REPEAT_ALLOWED) begin : g_repeat
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_q;
    logic [RPT_W-1:0] rpt_target;
    logic             periodic_q;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; any exit from HELD restarts at zero.
    assign rpt_target = periodic_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
    assign rpt_fire   = (state_q == HELD) && sync && (rpt_q == rpt_target);

    always_ff @(posedge clk) begin
      if (reset || state_q != HELD) begin
        rpt_q      <= '0;
        periodic_q <= 1'b0;
      end else if (rpt_fire) begin
        rpt_q      <= '0;
        periodic_q <= 1'b1;
      end else begin
        rpt_q <= rpt_q + 1'b1;
      end
    end
  end else begin : g_no_repeat
    assign rpt_fire = 1'b0;
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, REPEAT_ALLOWED};
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse   <= 1'b0;
      level   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse   <= press_accept | rpt_fire;
      level   <= (state_d == HELD) || (state_d == RELEASE_WAIT);
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Seven-button front end: synchronise, debounce and pulse each pad for the game FSM.
// Define AUTO_REPEAT_EN to enable auto-repeat on the four direction buttons.
module button_conditioner
  import sudoku_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BTN_COUNT-1:0] buttons_raw,
  output logic                 up_button,
  output logic                 down_button,
  output logic                 left_button,
  output logic                 right_button,
  output logic                 start_button,
  output logic                 a_button,
  output logic                 b_button,
  output logic [BTN_COUNT-1:0] buttons_level
);

  logic [BTN_COUNT-1:0] pulses;

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_ALLOWED  (i <= BTN_RIGHT)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (buttons_raw[i]),
      .pulse (pulses[i]),
      .level (buttons_level[i])
    );
  end

  assign up_button    = pulses[BTN_UP];
  assign down_button  = pulses[BTN_DOWN];
  assign left_button  = pulses[BTN_LEFT];
  assign right_button = pulses[BTN_RIGHT];
  assign start_button = pulses[BTN_START];
  assign a_button     = pulses[BTN_A];
  assign b_button     = pulses[BTN_B];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: vector table, directed corner cases, random run vs model.
module tb_button_conditioner;
  import sudoku_pkg::*;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] buttons_raw;
  logic       up_button, down_button, left_button, right_button;
  logic       start_button, a_button, b_button;
  logic [6:0] buttons_level;
  logic [6:0] obs_p;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons_raw   (buttons_raw),
    .up_button     (up_button),
    .down_button   (down_button),
    .left_button   (left_button),
    .right_button  (right_button),
    .start_button  (start_button),
    .a_button      (a_button),
    .b_button      (b_button),
    .buttons_level (buttons_level)
  );

  assign obs_p = {b_button, a_button, start_button, right_button, left_button, down_button, up_button};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pulse_cnt [7];

  // Reference: raw seen two edges late; level flips after D consecutive disagreeing samples.
  logic [6:0]  h1, h2, m_lvl, m_pulse;
  int unsigned run [7];
  int unsigned age [7];

  typedef struct {
    logic [6:0] raw;
    logic       rst;
    logic [6:0] p;
    logic [6:0] l;
  } vec_t;
  vec_t tbl [$];

  task automatic check_vec(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic void model_edge(input logic [6:0] raw_v, input logic rst_v);
    if (rst_v) begin
      h1 = '0; h2 = '0; m_lvl = '0; m_pulse = '0;
      for (int ch = 0; ch < 7; ch++) begin
        run[ch] = 0;
        age[ch] = 0;
      end
    end else begin
      for (int ch = 0; ch < 7; ch++) begin
        logic sv;
        sv = h2[ch];
        m_pulse[ch] = 1'b0;
`ifdef AUTO_REPEAT_EN
        if (ch <= BTN_RIGHT) begin
          if (m_lvl[ch] && run[ch] == 0 && sv) begin
            age[ch]++;
            if (age[ch] == RD || (age[ch] > RD && (age[ch] - RD) % RP == 0)) m_pulse[ch] = 1'b1;
          end else begin
            age[ch] = 0;
          end
        end
`endif
        if (sv != m_lvl[ch]) begin
          run[ch]++;
          if (run[ch] == D) begin
            m_lvl[ch] = sv;
            run[ch] = 0;
            if (sv) m_pulse[ch] = 1'b1;
          end
        end else begin
          run[ch] = 0;
        end
      end
      h2 = h1;
      h1 = raw_v;
    end
  endfunction

  task automatic step(input logic [6:0] raw_v, input logic rst_v);
    buttons_raw = raw_v;
    reset = rst_v;
    @(posedge clk);
    model_edge(raw_v, rst_v);
    #1;
    cyc++;
    check_vec("model_pulse", obs_p, m_pulse);
    check_vec("model_level", buttons_level, m_lvl);
    for (int ch = 0; ch < 7; ch++) if (obs_p[ch]) pulse_cnt[ch]++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(7'b0, 1'b0);
  endtask

  function automatic void add(input logic [6:0] r, input logic rs, input logic [6:0] p, input logic [6:0] l);
    vec_t v;
    v.raw = r; v.rst = rs; v.p = p; v.l = l;
    tbl.push_back(v);
  endfunction

  initial begin
    int base;
    int off [$];
    logic [6:0] r;
    reset = 1'b1;
    buttons_raw = '0;
    for (int ch = 0; ch < 7; ch++) pulse_cnt[ch] = 0;

    // Up press and release, hand-derived expectations.
    add(7'd0, 1'b1, 7'd0, 7'd0);
    add(7'd0, 1'b1, 7'd0, 7'd0);
    for (int i = 0; i < 8; i++)
      add(7'd1, 1'b0, (i == 5) ? 7'd1 : 7'd0, (i >= 5) ? 7'd1 : 7'd0);
    for (int i = 0; i < 7; i++)
      add(7'd0, 1'b0, 7'd0, (i < 5) ? 7'd1 : 7'd0);
    foreach (tbl[i]) begin
      step(tbl[i].raw, tbl[i].rst);
      check_vec("tbl_pulse", obs_p, tbl[i].p);
      check_vec("tbl_level", buttons_level, tbl[i].l);
    end

    // Long hold of up: single pulse six cycles after the rise.
    base = pulse_cnt[BTN_UP];
    for (int i = 1; i <= 50; i++) begin
      step(7'd1, 1'b0);
      if (i == 6) check_vec("hold_first_pulse", obs_p, 7'b0000001);
    end
`ifndef AUTO_REPEAT_EN
    check_int("hold_no_repeat", pulse_cnt[BTN_UP] - base, 1);
`endif
    idle(8);

    // Bounce on a, then steady press.
    base = pulse_cnt[BTN_A];
    step(7'b0100000, 1'b0); step(7'b0000000, 1'b0); step(7'b0100000, 1'b0);
    step(7'b0100000, 1'b0); step(7'b0000000, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(7'b0100000, 1'b0);
      if (i == 6) check_vec("bounce_pulse_time", obs_p, 7'b0100000);
    end
    check_int("bounce_one_pulse", pulse_cnt[BTN_A] - base, 1);
    idle(8);

    // Short release glitch on start.
    base = pulse_cnt[BTN_START];
    for (int i = 0; i < 10; i++) step(7'b0010000, 1'b0);
    step(7'b0, 1'b0); step(7'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(7'b0010000, 1'b0);
      check_vec("glitch_level", buttons_level, 7'b0010000);
    end
    check_int("glitch_one_pulse", pulse_cnt[BTN_START] - base, 1);
    idle(8);

    // Up and b together.
    for (int i = 1; i <= 10; i++) begin
      step(7'b1000001, 1'b0);
      if (i == 6) check_vec("simultaneous", obs_p, 7'b1000001);
    end
    idle(8);

    // Reset in the middle of a press debounce.
    for (int i = 0; i < 4; i++) step(7'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(7'd1, 1'b1);
      check_vec("reset_pulses", obs_p, 7'd0);
      check_vec("reset_level", buttons_level, 7'd0);
    end
    for (int i = 1; i <= 8; i++) begin
      step(7'd1, 1'b0);
      if (i == 6) check_vec("after_reset_pulse", obs_p, 7'd1);
    end
    idle(8);

`ifdef AUTO_REPEAT_EN
    // Auto-repeat on right; start never repeats.
    base = cyc;
    for (int i = 0; i < 30; i++) begin
      step(7'b0001000, 1'b0);
      if (obs_p[BTN_RIGHT]) off.push_back(cyc);
    end
    idle(8);
    check_int("repeat_count_min", (off.size() >= 7) ? 1 : 0, 1);
    if (off.size() >= 7) begin
      check_int("repeat_off1", off[1] - off[0], 8);
      check_int("repeat_off2", off[2] - off[0], 11);
      check_int("repeat_off3", off[3] - off[0], 14);
      check_int("repeat_off6", off[6] - off[0], 23);
    end
    base = pulse_cnt[BTN_START];
    for (int i = 0; i < 30; i++) step(7'b0010000, 1'b0);
    check_int("start_no_repeat", pulse_cnt[BTN_START] - base, 1);
    idle(8);
`endif

    // Random bouncy activity with occasional resets.
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 6)] ^= 1'b1;
      step(r, ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
